mul_256b_seq_ctrl: RTL and testbench

Sequencer that computes a 256x256-bit unsigned product by time-multiplexing one external 64x64-bit unsigned multiplier.
- Splits each operand into four 64-bit words and issues the 16 word-pair products, one per cycle.
- Accumulates each 128-bit partial product into a 512-bit result at bit offset 64*(i+j).
- Sits between the SM2 modular-arithmetic unit (the requester) and the shared 64b multiplier instance.

---
 rtl/mul_seq_pkg.sv | 43 ++++
 rtl/mul_seq_tag_pipe.sv | 40 ++++
 rtl/mul_256b_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_mul_256b_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the 256x256 sequential multiply controller:
// word geometry, FSM encoding, retire-tag layout and the squaring issue order.
package mul_seq_pkg;

  localparam int W     = 64;
  localparam int NWORD = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // shift is the word offset i+j; dbl adds one extra bit of shift (x2 cross term)
  typedef struct packed {
    logic       valid;
    logic [2:0] shift;
    logic       dbl;
  } tag_t;

  localparam logic [3:0] LAST_K_FULL = 4'd15;
  localparam logic [3:0] LAST_K_SQ   = 4'd9;

  // Squaring visits only i<=j; the result uses the same {i,j} packing as a full k.
  function automatic logic [3:0] sq_pair(input logic [3:0] k);
    logic [3:0] p;
    case (k)
      4'd0:    p = 4'h0;
      4'd1:    p = 4'h1;
      4'd2:    p = 4'h2;
      4'd3:    p = 4'h3;
      4'd4:    p = 4'h5;
      4'd5:    p = 4'h6;
      4'd6:    p = 4'h7;
      4'd7:    p = 4'hA;
      4'd8:    p = 4'hB;
      default: p = 4'hF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mul_seq_tag_pipe.sv
// Delay line that carries retire tags alongside the external multiplier.
// DEPTH=0 is a pure pass-through; pend_o flags any tag still held in a stage.
module mul_seq_tag_pipe
  import mul_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic pend_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign tag_o  = tag_i;
      assign pend_o = 1'b0;
    end else begin : g_reg
      tag_t stage_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= tag_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) pend_o = pend_o | stage_q[i].valid;
      end

      assign tag_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mul_256b_seq_ctrl.sv
// 256x256 unsigned multiply built from 16 (or 10 when squaring) word products
// on one shared 64x64 multiplier. Squaring shortcut is built with SQUARE_OPT_EN.
module mul_256b_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and data stable until that edge.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NWORD*W-1:0]   in_a,
  input  logic [NWORD*W-1:0]   in_b,
  input  logic                 in_sq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*NWORD*W-1:0] out_p,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_p,
  output logic                 busy,
  output state_e               dbg_state
);

`ifdef SQUARE_OPT_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [3:0]             k_q, k_d;
  logic [NWORD*W-1:0]     a_q, a_d, b_q, b_d;
  logic                   sq_q, sq_d;
  logic [2*NWORD*W-1:0]   acc_q, acc_d;
  logic [W-1:0]           mul_a_q, mul_b_q;

  logic                   issue;
  logic [3:0]             pair, last_k;
  logic [1:0]             wi, wj;
  tag_t                   tag_in, tag_out;
  logic                   pend;
  logic [8:0]             sh;
  logic [2*NWORD*W-1:0]   pp;

  assign issue  = (state_q == S_ISSUE);
  assign pair   = sq_q ? sq_pair(k_q) : k_q;
  assign wi     = pair[3:2];
  assign wj     = pair[1:0];
  assign last_k = sq_q ? LAST_K_SQ : LAST_K_FULL;

  // Outside ISSUE the multiplier inputs repeat the last issued words.
  assign mul_a  = issue ? a_q[{wi, 6'b0} +: W] : mul_a_q;
  assign mul_b  = issue ? b_q[{wj, 6'b0} +: W] : mul_b_q;

  assign tag_in.valid = issue;
  assign tag_in.shift = {1'b0, wi} + {1'b0, wj};
  assign tag_in.dbl   = sq_q & (wi != wj);

  mul_seq_tag_pipe #(.DEPTH(MUL_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (tag_in),
    .tag_o  (tag_out),
    .pend_o (pend)
  );

  assign sh = {tag_out.shift, 6'b0} + {8'b0, tag_out.dbl};
  assign pp = {{(2*NWORD*W-2*W){1'b0}}, mul_p} << sh;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    if (tag_out.valid) acc_d = acc_q + pp;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sq_d    = in_sq & SQ_EN;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        k_d = k_q + 4'd1;
        if (k_q == last_k) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end
      end
      // Leave only once no tag remains in flight in the delay line.
      S_DRAIN: if (!pend) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sq_q    <= 1'b0;
      acc_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a;
      mul_b_q <= mul_b;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_p     = out_valid ? acc_q : '0;
  assign busy      = !in_ready;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_256b_seq_ctrl.sv
// Bench for mul_256b_seq_ctrl: main instance at MUL_LAT=1 with a product/timing
// model, plus three small lanes at MUL_LAT=0,2,4 for latency and all-ones product.
module tb_mul_256b_seq_ctrl;
  import mul_seq_pkg::*;

  localparam int L = 1;
`ifdef SQUARE_OPT_EN
  localparam bit SQ_BUILD = 1'b1;
`else
  localparam bit SQ_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_sq, out_valid, out_ready, busy;
  logic [255:0] in_a, in_b;
  logic [511:0] out_p;
  logic [63:0]  mul_a, mul_b;
  logic [127:0] mul_p, mp_q;
  state_e       dbg_state;

  mul_256b_seq_ctrl #(.MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sq(in_sq), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .busy(busy), .dbg_state(dbg_state)
  );

  // external multiplier, one register stage
  always @(posedge clk) mp_q <= 128'(mul_a) * 128'(mul_b);
  assign mul_p = mp_q;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [511:0] exp_q[$];
  int  cyc = 0;
  bit  m_busy = 1'b0;
  int  m_acc_cyc = 0;
  int  m_lat = 0;
  int  op_id = 0;
  logic m_ov;
  assign m_ov = m_busy && ((cyc - m_acc_cyc) > m_lat);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      exp_q.delete();
    end else if (!m_busy && in_valid) begin
      exp_q.push_back(512'(in_a) * 512'(in_b));
      m_busy    <= 1'b1;
      m_acc_cyc <= cyc;
      m_lat     <= (SQ_BUILD && in_sq) ? 11 + L : 17 + L;
      op_id     <= op_id + 1;
    end else if (m_ov && out_ready) begin
      void'(exp_q.pop_front());
      m_busy <= 1'b0;
    end
  end

  // compare process
  int seen_id = 0;
  int meas_lat = 0;
  logic [511:0] last_out_p = '0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", {511'b0, in_ready}, {511'b0, !m_busy});
      check("busy", {511'b0, busy}, {511'b0, m_busy});
      check("out_valid", {511'b0, out_valid}, {511'b0, m_ov});
      if (m_ov && exp_q.size() > 0) check("out_p", out_p, exp_q[0]);
      if (m_busy && out_valid && seen_id != op_id) begin
        seen_id    = op_id;
        meas_lat   = cyc - m_acc_cyc - 1;
        last_out_p = out_p;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [255:0] a, input logic [255:0] b, input logic sq, input bit keep);
    bit acc;
    acc = 1'b0;
    in_a = a; in_b = b; in_sq = sq; in_valid = 1'b1;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(posedge clk);
      acc = !m_busy;
      #1;
    end
    if (!acc) check("accept_timeout", 512'd0, 512'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!m_busy) return;
    end
    check("idle_timeout", 512'd0, 512'd1);
  endtask

  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic sq,
                        input logic [511:0] exp_p, input int exp_lat, input string name);
    send(a, b, sq, 1'b0);
    wait_idle();
    check({name, "_prod"}, last_out_p, exp_p);
    check({name, "_lat"}, 512'(meas_lat), 512'(exp_lat));
  endtask

  // ---------------- extra latency lanes ----------------
  logic [255:0] all_ones;
  assign all_ones = '1;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LL = (g == 0) ? 0 : ((g == 1) ? 2 : 4);
    localparam int IX = (LL == 0) ? 0 : LL - 1;
    logic         l_in_valid, l_in_ready, l_out_valid, l_busy;
    logic [511:0] l_out_p, l_exp;
    logic [63:0]  l_ma, l_mb;
    logic [127:0] l_mp;
    logic [127:0] l_pipe [5];
    state_e       l_dbg;
    bit           done = 1'b0;

    mul_256b_seq_ctrl #(.MUL_LAT(LL)) u_lane (
      .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .in_a(all_ones), .in_b(all_ones), .in_sq(1'b0), .out_valid(l_out_valid),
      .out_ready(1'b1), .out_p(l_out_p), .mul_a(l_ma), .mul_b(l_mb),
      .mul_p(l_mp), .busy(l_busy), .dbg_state(l_dbg)
    );

    always @(posedge clk) begin
      l_pipe[0] <= 128'(l_ma) * 128'(l_mb);
      for (int i = 1; i < 5; i++) l_pipe[i] <= l_pipe[i-1];
    end
    assign l_mp = (LL == 0) ? 128'(l_ma) * 128'(l_mb) : l_pipe[IX];

    initial begin
      int m;
      bit ok;
      l_in_valid = 1'b0;
      l_exp = '1;
      l_exp = l_exp - (512'd1 << 257) + 512'd2;
      wait (chk_en);
      @(posedge clk); #1;
      l_in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
        @(negedge clk);
        ok = l_in_ready;
      end
      @(posedge clk); #1;
      l_in_valid = 1'b0;
      for (m = 0; m < 60; m++) begin
        @(negedge clk);
        if (l_out_valid) break;
      end
      check($sformatf("lane%0d_lat", LL), 512'(m), 512'(17 + LL));
      check($sformatf("lane%0d_prod", LL), l_out_p, l_exp);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [511:0] e;
    logic [255:0] ra, rb;
    bit lanes_ok;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sq = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {511'b0, in_ready}, 512'd1);
    check("rst_out_valid", {511'b0, out_valid}, 512'd0);
    check("rst_out_p", out_p, 512'd0);
    check("rst_busy", {511'b0, busy}, 512'd0);
    check("rst_mul_a", {448'b0, mul_a}, 512'd0);
    check("rst_mul_b", {448'b0, mul_b}, 512'd0);
    check("rst_state", {510'b0, dbg_state}, {510'b0, S_IDLE});
    chk_en = 1'b1;

    run_op(256'd1, 256'd1, 1'b0, 512'd1, 18, "one");

    e = '1;
    e = e - (512'd1 << 257) + 512'd2;
    run_op('1, '1, 1'b0, e, 18, "ones");

    // product held while the requester stalls; a new request must be ignored
    out_ready = 1'b0;
    send(256'd1 << 255, (256'd1 << 255) + 256'd3, 1'b0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_ov) break;
    end
    in_a = 256'd7; in_b = 256'd7; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_out_p", out_p, (512'd1 << 510) + (512'd3 << 255));
    check("hold_in_ready", {511'b0, in_ready}, 512'd0);
    check("hold_lat", 512'(meas_lat), 512'd18);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    // reset pulsed while the k=7 product is being issued
    send('1, '1, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {511'b0, out_valid}, 512'd0);
    check("abort_busy", {511'b0, busy}, 512'd0);
    check("abort_in_ready", {511'b0, in_ready}, 512'd1);
    check("abort_mul_a", {448'b0, mul_a}, 512'd0);
    run_op(256'd3, 256'd5, 1'b0, 512'd15, 18, "after_abort");

`ifdef SQUARE_OPT_EN
    e = 512'd1 + (512'd2 << 64) + (512'd3 << 128) + (512'd4 << 192)
      + (512'd3 << 256) + (512'd2 << 320) + (512'd1 << 384);
    run_op({4{64'd1}}, {4{64'd1}}, 1'b1, e, 12, "square");
    run_op({4{64'd1}}, {4{64'd1}}, 1'b0, e, 18, "square_off");
`else
    run_op(256'd5, 256'd7, 1'b1, 512'd35, 18, "sq_ignored");
`endif

    // back-to-back random traffic
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      for (int w = 0; w < 8; w++) begin
        ra[32*w +: 32] = $urandom;
        rb[32*w +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
      end
      send(ra, rb, 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    wait_idle();

    lanes_ok = 1'b0;
    for (int n = 0; n < 200 && !lanes_ok; n++) begin
      @(negedge clk);
      lanes_ok = g_lane[0].done && g_lane[1].done && g_lane[2].done;
    end
    check("lanes_done", {511'b0, lanes_ok}, 512'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
